// File: rtl/stack_unit.sv
// stack_unit - LIFO stack for the multicycle stack processor.
//
// Holds up to DEPTH words of WIDTH bits. The top of stack is presented
// combinationally on data_out; count, full and empty come from registered
// state only. Sticky overflow/underflow flags record illegal accesses until
// cleared with clear_err.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   resetN     synchronous active-low reset (count and flags only)
//   push       write data_in onto the stack at this edge
//   pop        remove the top entry at this edge
//   data_in    word to push
//   data_out   current top entry, 0 when empty
//   full       count == DEPTH
//   empty      count == 0
//   count      number of valid entries
//   overflow   sticky: push while full without pop
//   underflow  sticky: pop while empty
//   clear_err  clears overflow/underflow at this edge
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic [CW-1:0] top_idx;
  logic [AW-1:0] top_addr;
  logic [AW-1:0] count_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          ovf_evt;
  logic          unf_evt;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

  assign top_idx    = count_reg - CW'(1);
  assign top_addr   = top_idx[AW-1:0];
  assign count_addr = count_reg[AW-1:0];

  // The only combinational path: registered count/mem to the top word.
  assign data_out   = empty ? '0 : mem_reg[top_addr];

  always_comb begin
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_addr    = count_addr;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en      = 1'b1;
          count_next = count_reg + CW'(1);
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          count_next = count_reg - CW'(1);
        end else begin
          unf_evt = 1'b1;
        end
      end
      2'b11: begin
        // Simultaneous push+pop replaces the top in place, which is why it
        // is legal even when full. On an empty stack the pop half has
        // nothing to remove, so it degrades to a plain push into entry 0
        // and still flags the underflow.
        wr_en = 1'b1;
        if (empty) begin
          count_next = CW'(1);
          unf_evt    = 1'b1;
        end else begin
          wr_addr = top_addr;
        end
      end
      default: ;
    endcase
    // A new error event beats clear_err in the same cycle.
    overflow_next  = ovf_evt | (overflow_reg  & ~clear_err);
    underflow_next = unf_evt | (underflow_reg & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage has no reset; stale entries are never visible because data_out
  // is gated by count.
  always_ff @(posedge clk) begin
    if (resetN && wr_en) begin
      mem_reg[wr_addr] <= data_in;
    end
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO stack serving the multicycle stack processor. The processor drives push/pop strobes and write data; the stack returns the current top-of-stack combinationally, plus full/empty status. Depth and width are parameters, and the default configuration matches the processor's 8-bit datapath. Sticky overflow/underflow flags record illegal accesses for debug and verification.

## Interface
- WIDTH, 8, data word width
- DEPTH, 16, number of entries (≥2)
- clk  input  1  clock; all state updates on rising edge
- resetN  input  1  reset, synchronous, active-low
- push  input  1  write data_in onto stack at this edge
- pop  input  1  remove top entry at this edge
- data_in  input  WIDTH  word to push (processor's stack_data_out)
- data_out  output  WIDTH  current top entry, combinational (processor's stack_data_in)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH+1)  number of valid entries
- overflow  output  1  sticky: push attempted while full without pop
- underflow  output  1  sticky: pop attempted while empty
- clear_err  input  1  clears overflow/underflow at this edge

## Operation
- Storage: DEPTH×WIDTH register array, plus pointer count (0..DEPTH). Entry count-1 is the top. Array contents are not reset.
- data_out = mem[count-1] when count>0, else 0. It updates in the same cycle that count/mem change; there is no registered read latency.
- full = (count==DEPTH); empty = (count==0). Both are derived from registered count.
- Edge actions, evaluated on the pre-edge state:
  - push only, not full: mem[count] ← data_in; count+1.
  - push only, full: no write, count unchanged, overflow ← 1.
  - pop only, not empty: count−1; the entry is not cleared.
  - pop only, empty: count unchanged, underflow ← 1.
  - push+pop, not empty: replace top. mem[count-1] ← data_in; count unchanged. This is legal when full.
  - push+pop, empty: treated as push. mem[0] ← data_in, count=1, underflow ← 1.
  - neither: hold.
- clear_err=1: overflow and underflow ← 0. A new error event in the same cycle wins, leaving the flag at 1.
- A popped value is valid on data_out during the cycle pop is asserted and is consumed at that edge. Consecutive pops on consecutive cycles return successive entries.

## Timing
- Reset (resetN=0 at edge): count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0. Reset has priority over push/pop/clear_err in the same cycle.
- Reset mid-operation discards all entries. The first push after reset lands in mem[0].
- Push latency: data_in pushed at edge N appears on data_out after edge N (cycle N+1).
- Pop: data_out shows the entry consumed at edge N during cycle N. After edge N, data_out shows the next-lower entry, or 0 if the stack is now empty.
- Status outputs change only on clock edges. No combinational path exists from push/pop to full/empty/count.
- Only combinational path: count/mem → data_out. There is no path from data_in to data_out.
- The block has no enable. The processor's haltN is realised by holding push=pop=0.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on three cycles. Expect count=3 and data_out=0x33. Then pop three cycles and sample data_out each cycle: 0x33, 0x22, 0x11. Afterwards empty=1, data_out=0x00, underflow=0.
- Fill DEPTH=16 with values 0..15. Expect full=1 and data_out=0x0F. Push 0xAA: expect overflow=1, count=16, data_out=0x0F. Then push+pop 0x55: expect data_out=0x55 and count=16.
- Empty stack, pop: expect underflow=1 and count=0. Assert clear_err: expect underflow=0. Next, push+pop 0x77 on an empty stack: expect count=1, data_out=0x77, underflow=1.
- Processor add pattern: push 0x05, push 0x03, then pop held for 2 cycles. Sampled data_out must be 0x03 then 0x05. Then push 0x08: expect count=1, data_out=0x08.
- Push 0x10, 0x20, then assert resetN=0 together with push=1, data_in=0x30. Expect count=0, empty=1, data_out=0. A subsequent push 0x40 must give data_out=0x40 and count=1.
- Simultaneous clear_err and overflowing push while full: expect overflow=1 after the edge.
